// File: rtl/pc_choose_pkg.sv
// ---------------------------------------------------------------------------
// pc_choose_pkg
//   Shared definitions for the program-counter select block:
//   - default bus width and reset vector
//   - pc_src encodings reported alongside the registered PC
// ---------------------------------------------------------------------------
package pc_choose_pkg;

  // Default width of every address bus and of the PC register.
  localparam int unsigned PC_WIDTH_DEFAULT = 32;

  // Default address loaded into PC while reset is asserted.
  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Source of the current PC value. The encoding is visible on the pc_src
  // port, so these values are part of the external interface.
  typedef enum logic [1:0] {
    PCSRC_RESET  = 2'b00,
    PCSRC_SEQ    = 2'b01,
    PCSRC_BRANCH = 2'b10,
    PCSRC_JUMP   = 2'b11
  } pc_src_e;

endpackage : pc_choose_pkg

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
//   Purely combinational next-PC selection. Priority is
//   jump > taken branch > sequential (PC + 4).
//
// Ports
//   i_pc4          sequential next address (current PC + 4)
//   i_branch_addr  branch target address
//   i_jump_addr    jump target address
//   i_beq          instruction is branch-if-equal
//   i_bne          instruction is branch-if-not-equal
//   i_zero         ALU zero flag (1 = operands equal)
//   i_jump         instruction is an unconditional jump
//   o_next_addr    selected next address, passed through unmodified
//   o_pc_src       source of o_next_addr
// ---------------------------------------------------------------------------
module pc_next_sel
  import pc_choose_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_pc4,
  input  logic [WIDTH-1:0] i_branch_addr,
  input  logic [WIDTH-1:0] i_jump_addr,
  input  logic             i_beq,
  input  logic             i_bne,
  input  logic             i_zero,
  input  logic             i_jump,
  output logic [WIDTH-1:0] o_next_addr,
  output pc_src_e          o_pc_src
);

  logic w_branch_taken;

  // With beq and bne both set exactly one condition holds, so the branch is
  // always taken; that combination is deliberately not flagged.
  assign w_branch_taken = (i_beq & i_zero) | (i_bne & ~i_zero);

  // Only the selected address reaches the output, so X on an unselected
  // address input cannot leak into the PC.
  always_comb begin
    o_next_addr = i_pc4;
    o_pc_src    = PCSRC_SEQ;
    if (i_jump) begin
      o_next_addr = i_jump_addr;
      o_pc_src    = PCSRC_JUMP;
    end else if (w_branch_taken) begin
      o_next_addr = i_branch_addr;
      o_pc_src    = PCSRC_BRANCH;
    end
  end

endmodule : pc_next_sel

// File: rtl/pc_choose.sv
// ---------------------------------------------------------------------------
// pc_choose
//   Program-counter register. Selects the next PC among PC+4, a branch
//   target and a jump target (via pc_next_sel) and registers it together
//   with a code identifying which source was used.
//
// Ports
//   clk         sole clock, rising-edge active
//   reset       asynchronous active-low reset (0 = reset, 1 = run)
//   PC4         sequential next address (current PC + 4)
//   branchAddr  branch target address
//   jumpAddr    jump target address
//   beq         instruction is branch-if-equal
//   bne         instruction is branch-if-not-equal
//   zero        ALU zero flag (1 = operands equal)
//   jump        instruction is an unconditional jump
//   PC          registered program counter
//   pc_src      registered source of PC (00 reset, 01 PC4, 10 branch, 11 jump)
// ---------------------------------------------------------------------------
module pc_choose
  import pc_choose_pkg::*;
#(
  parameter int unsigned      WIDTH        = PC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC4,
  input  logic [WIDTH-1:0] branchAddr,
  input  logic [WIDTH-1:0] jumpAddr,
  input  logic             beq,
  input  logic             bne,
  input  logic             zero,
  input  logic             jump,
  output logic [WIDTH-1:0] PC,
  output logic [1:0]       pc_src
);

  logic [WIDTH-1:0] w_next_addr;
  pc_src_e          w_next_src;

  logic [WIDTH-1:0] r_pc;
  pc_src_e          r_pc_src;

  pc_next_sel #(
    .WIDTH (WIDTH)
  ) u_pc_next_sel (
    .i_pc4         (PC4),
    .i_branch_addr (branchAddr),
    .i_jump_addr   (jumpAddr),
    .i_beq         (beq),
    .i_bne         (bne),
    .i_zero        (zero),
    .i_jump        (jump),
    .o_next_addr   (w_next_addr),
    .o_pc_src      (w_next_src)
  );

  // PC and its source code always move together on the same edge; reset
  // takes effect immediately and masks every clock edge while low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_VECTOR;
      r_pc_src <= PCSRC_RESET;
    end else begin
      r_pc     <= w_next_addr;
      r_pc_src <= w_next_src;
    end
  end

  assign PC     = r_pc;
  assign pc_src = r_pc_src;

endmodule : pc_choose

// File: tb/tb_pc_choose.sv
// ---------------------------------------------------------------------------
// tb_pc_choose
//   Self-checking bench for pc_choose: directed vectors with literal
//   expectations plus a behavioural model compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_pc_choose;

  logic        clk;
  logic        reset;
  logic [31:0] PC4;
  logic [31:0] branchAddr;
  logic [31:0] jumpAddr;
  logic        beq;
  logic        bne;
  logic        zero;
  logic        jump;
  logic [31:0] PC;
  logic [1:0]  pc_src;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc;
  logic [1:0]  m_src;

  pc_choose dut (
    .clk        (clk),
    .reset      (reset),
    .PC4        (PC4),
    .branchAddr (branchAddr),
    .jumpAddr   (jumpAddr),
    .beq        (beq),
    .bne        (bne),
    .zero       (zero),
    .jump       (jump),
    .PC         (PC),
    .pc_src     (pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rule-level prediction: {source, address} the PC must hold after an edge.
  function automatic logic [33:0] predict(input logic [31:0] pc4, input logic [31:0] ba,
                                          input logic [31:0] ja, input logic eq_br,
                                          input logic ne_br, input logic z, input logic j);
    bit cond_ok;
    if (j) return {2'd3, ja};
    cond_ok = 1'b0;
    if (eq_br && z)  cond_ok = 1'b1;  // equal operands satisfy beq
    if (ne_br && !z) cond_ok = 1'b1;  // unequal operands satisfy bne
    if (cond_ok) return {2'd2, ba};
    return {2'd1, pc4};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc  <= 32'h0;
      m_src <= 2'd0;
    end else begin
      {m_src, m_pc} <= predict(PC4, branchAddr, jumpAddr, beq, bne, zero, jump);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", PC, m_pc);
      chk("model_src", {30'd0, pc_src}, {30'd0, m_src});
    end
  end

  task automatic apply(input logic [31:0] pc4, input logic [31:0] ba, input logic [31:0] ja,
                       input logic eq_br, input logic ne_br, input logic z, input logic j);
    PC4        = pc4;
    branchAddr = ba;
    jumpAddr   = ja;
    beq        = eq_br;
    bne        = ne_br;
    zero       = z;
    jump       = j;
  endtask

  task automatic step_chk(input string name, input logic [31:0] exp_pc,
                          input logic [1:0] exp_src);
    @(posedge clk);
    #1;
    chk({name, "_pc"}, PC, exp_pc);
    chk({name, "_src"}, {30'd0, pc_src}, {30'd0, exp_src});
  endtask

  initial begin
    reset = 1'b1;
    apply(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_src", {30'd0, pc_src}, 32'h0);

    // Edges during reset are ignored.
    apply(32'h8, 32'h10, 32'h14, 1'b1, 1'b0, 1'b1, 1'b1);
    step_chk("reset_hold", 32'h0, 2'b00);
    #3;
    reset = 1'b1;

    apply(32'h8, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    step_chk("seq", 32'h8, 2'b01);
    apply(32'h8, 32'h10, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    step_chk("bne_taken", 32'h10, 2'b10);
    apply(32'h8, 32'h10, 32'h2, 1'b0, 1'b1, 1'b1, 1'b0);
    step_chk("bne_not_taken", 32'h8, 2'b01);
    apply(32'h4, 32'h20, 32'h2, 1'b1, 1'b0, 1'b1, 1'b0);
    step_chk("beq_taken", 32'h20, 2'b10);
    apply(32'h4, 32'h20, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    step_chk("beq_not_taken", 32'h4, 2'b01);
    apply(32'h4, 32'h20, 32'h14, 1'b1, 1'b0, 1'b1, 1'b1);
    step_chk("jump_prio", 32'h14, 2'b11);

    // Mid-cycle reset with PC=0x14 clears PC before the next edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_pc", PC, 32'h0);
    chk("async_reset_src", {30'd0, pc_src}, 32'h0);
    #3;
    reset = 1'b1;
    apply(32'h8, 32'h30, 32'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    step_chk("post_reset", 32'h8, 2'b01);

    // beq and bne together: always taken.
    apply(32'h8, 32'h44, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
    step_chk("both_z0", 32'h44, 2'b10);
    apply(32'h8, 32'h4c, 32'h48, 1'b1, 1'b1, 1'b1, 1'b0);
    step_chk("both_z1", 32'h4c, 2'b10);

    // Inputs changing between edges must not disturb PC.
    apply(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step_chk("hold_base", 32'h40, 2'b01);
    #2;
    apply(32'h44, 32'h50, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("hold_mid1", PC, 32'h40);
    #2;
    chk("hold_mid2", PC, 32'h40);
    apply(32'h48, 32'h60, 32'h99, 1'b1, 1'b0, 1'b1, 1'b0);
    step_chk("hold_next", 32'h60, 2'b10);

    // Unknown values on unselected address inputs.
    apply(32'h100, 32'hx, 32'hx, 1'b0, 1'b0, 1'b1, 1'b0);
    step_chk("x_unselected", 32'h100, 2'b01);

    // Sweep every control combination; the model checks each result.
    for (int c = 0; c < 16; c++) begin
      apply(32'h1000 + 32'(c) * 4, 32'h2000 + 32'(c), 32'h3000 + 32'(c),
            c[3], c[2], c[1], c[0]);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_choose

// File: doc/pc_choose.md
PC_CHOOSE -- requirements
Module: pc_choose

Interface
REQ-001 Parameter WIDTH, default 32: width of every address bus and of PC.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: value loaded into PC during reset.
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous active-low reset (0 = reset, 1 = run).
REQ-006 Port PC4, input, WIDTH bits: sequential next address (current PC + 4), computed upstream.
REQ-007 Port branchAddr, input, WIDTH bits: branch target address, computed upstream.
REQ-008 Port jumpAddr, input, WIDTH bits: jump target address, computed upstream.
REQ-009 Port beq, input, 1 bit: current instruction is branch-if-equal.
REQ-010 Port bne, input, 1 bit: current instruction is branch-if-not-equal.
REQ-011 Port zero, input, 1 bit: ALU zero flag (1 = operands equal).
REQ-012 Port jump, input, 1 bit: current instruction is an unconditional jump.
REQ-013 Port PC, output, WIDTH bits: registered program counter.
REQ-014 Port pc_src, output, 2 bits: registered source of the current PC value (00 = reset, 01 = PC4, 10 = branch, 11 = jump).

Function
REQ-015 branch_taken SHALL be (beq AND zero) OR (bne AND NOT zero), evaluated combinationally.
REQ-016 Next-PC selection priority SHALL be jump > branch_taken > PC4.
REQ-017 jump=1 SHALL select jumpAddr regardless of beq, bne and zero.
REQ-018 beq=1 and bne=1 together SHALL always yield branch_taken=1 (one condition always holds); no error is flagged.
REQ-019 beq=0, bne=0, jump=0 SHALL select PC4 regardless of zero.
REQ-020 While reset=1, PC SHALL load the selected address on every rising clk edge; latency is exactly one cycle from inputs to PC.
REQ-021 pc_src SHALL update on the same edge as PC and encode the source used.
REQ-022 Addresses SHALL pass through unmodified: no alignment masking, no sign extension, no arithmetic inside the block.
REQ-023 PC SHALL hold its value between rising edges; input changes between edges SHALL NOT affect PC.
REQ-024 All inputs are sampled only at the rising edge; X on unselected address inputs SHALL NOT propagate to PC.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for a clock edge, force PC=RESET_VECTOR and pc_src=00.
REQ-026 While reset=0, clock edges SHALL be ignored.
REQ-027 The first rising edge after reset returns to 1 SHALL perform a normal update per REQ-016.
REQ-028 Reset asserted between edges SHALL override any pending update; no partial update is permitted.

Structure
REQ-029 A shared package SHALL hold the pc_src encodings (PCSRC_RESET, PCSRC_SEQ, PCSRC_BRANCH, PCSRC_JUMP) and the default WIDTH and RESET_VECTOR values.
REQ-030 The combinational selection (REQ-015 to REQ-019) SHALL be a sub-module named pc_next_sel, producing next address and pc_src; pc_choose adds only the register.

Verification
REQ-031 reset=0 mid-cycle with PC=0x14 -> PC=0x0 and pc_src=00 before the next edge; after release, PC4=0x8 with no control asserted -> PC=0x8 on the first edge.
REQ-032 PC4=0x8, branchAddr=0x1, jumpAddr=0x2, zero=0, bne=beq=jump=0, edge -> PC=0x8, pc_src=01.
REQ-033 PC4=0x8, branchAddr=0x10, zero=0, bne=1, edge -> PC=0x10, pc_src=10; repeat with zero=1 -> PC=0x8.
REQ-034 PC4=0x4, branchAddr=0x20, zero=1, beq=1, edge -> PC=0x20; repeat with zero=0 -> PC=0x4.
REQ-035 PC4=0x4, jumpAddr=0x14, jump=1, with beq=1 and zero=1 also asserted, edge -> PC=0x14, pc_src=11.
REQ-036 Change PC4 and all control inputs between edges -> PC stays constant until the next rising edge.
